ysyx_24100029_ifu: RTL and testbench

YSYX_24100029_IFU -- requirements
Module: ysyx_24100029_ifu

---
 rtl/ysyx_24100029_ifu.sv | 123 ++++++++++++
 tb/tb_ysyx_24100029_ifu.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100029_ifu.sv
// Instruction fetch unit: PC register, icache request handshake and optional BTB predictor.
// The BTB is built only when BRANCH_PREDICT_EN is defined; otherwise fetch is strictly sequential.
module ysyx_24100029_ifu #(
    parameter logic [31:0] RESET_PC        = 32'h3000_0000,
    parameter int          BTB_INDEX_WIDTH = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target,
    input  logic        upd_taken,
    input  logic        cpu_ready_i,
    output logic        cpu_valid_o,
    output logic [31:0] cpu_pc_o,
    output logic [31:0] pred_pc_o,
    output logic        pred_res_o
);

    logic [31:0] pc_r;
    logic [31:0] pc_d;
    logic        valid_r;
    logic [31:0] pc_plus4;
    logic [31:0] pred_pc;
    logic        pred_res;

    assign pc_plus4 = pc_r + 32'd4;

`ifdef BRANCH_PREDICT_EN
    localparam int N_ENT = 1 << BTB_INDEX_WIDTH;
    localparam int TAG_W = 30 - BTB_INDEX_WIDTH;

    logic [N_ENT-1:0]           btb_valid_q;
    logic [TAG_W-1:0]           btb_tag_q [N_ENT];
    logic [31:0]                btb_tgt_q [N_ENT];
    logic [1:0]                 btb_ctr_q [N_ENT];

    logic [BTB_INDEX_WIDTH-1:0] rd_idx;
    logic [BTB_INDEX_WIDTH-1:0] up_idx;
    logic [TAG_W-1:0]           rd_tag;
    logic [TAG_W-1:0]           up_tag;
    logic                       rd_hit;
    logic                       up_hit;
    logic [1:0]                 unused_upd;

    assign rd_idx     = pc_r[BTB_INDEX_WIDTH+1:2];
    assign rd_tag     = pc_r[31:BTB_INDEX_WIDTH+2];
    assign up_idx     = upd_pc[BTB_INDEX_WIDTH+1:2];
    assign up_tag     = upd_pc[31:BTB_INDEX_WIDTH+2];
    assign rd_hit     = btb_valid_q[rd_idx] && (btb_tag_q[rd_idx] == rd_tag);
    assign up_hit     = btb_valid_q[up_idx] && (btb_tag_q[up_idx] == up_tag);
    assign unused_upd = upd_pc[1:0];

    always_comb begin
        pred_res = 1'b0;
        pred_pc  = pc_plus4;
        if (rd_hit && btb_ctr_q[rd_idx][1]) begin
            pred_res = 1'b1;
            pred_pc  = btb_tgt_q[rd_idx];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            btb_valid_q <= '0;
        end else if (upd_valid && upd_taken && !up_hit) begin
            btb_valid_q[up_idx] <= 1'b1;
        end
    end

    // Payload is not reset: entries are qualified by btb_valid_q alone.
    always_ff @(posedge clock) begin
        if (!reset && upd_valid) begin
            if (up_hit) begin
                if (upd_taken) begin
                    btb_tgt_q[up_idx] <= upd_target;
                    if (btb_ctr_q[up_idx] != 2'b11) btb_ctr_q[up_idx] <= btb_ctr_q[up_idx] + 2'd1;
                end else if (btb_ctr_q[up_idx] != 2'b00) begin
                    btb_ctr_q[up_idx] <= btb_ctr_q[up_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                btb_tag_q[up_idx] <= up_tag;
                btb_tgt_q[up_idx] <= upd_target;
                btb_ctr_q[up_idx] <= 2'b10;
            end
        end
    end
`else
    logic unused_upd;

    assign unused_upd = ^{upd_valid, upd_pc, upd_target, upd_taken};
    assign pred_res   = 1'b0;
    assign pred_pc    = pc_plus4;
`endif

    // Reset forces the visible outputs so they are defined before the first edge.
    assign cpu_valid_o = valid_r & ~redirect_valid & ~reset;
    assign cpu_pc_o    = reset ? RESET_PC : pc_r;
    assign pred_pc_o   = reset ? (RESET_PC + 32'd4) : pred_pc;
    assign pred_res_o  = reset ? 1'b0 : pred_res;

    always_comb begin
        pc_d = pc_r;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (cpu_valid_o && cpu_ready_i) begin
            pc_d = pred_pc_o;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_r    <= RESET_PC;
            valid_r <= 1'b0;
        end else begin
            pc_r    <= pc_d;
            valid_r <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ysyx_24100029_ifu.sv
// Scoreboard bench for ysyx_24100029_ifu; BTB expectations follow BRANCH_PREDICT_EN.
module tb_ysyx_24100029_ifu;

`ifdef BRANCH_PREDICT_EN
    localparam bit BP = 1'b1;
`else
    localparam bit BP = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic        cpu_ready_i;
    logic        cpu_valid_o;
    logic [31:0] cpu_pc_o;
    logic [31:0] pred_pc_o;
    logic        pred_res_o;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [31:0] ppc;
        logic        pres;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];
    int    total = 0;
    int    bad   = 0;

    ysyx_24100029_ifu dut (
        .clock          (clock),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_target     (upd_target),
        .upd_taken      (upd_taken),
        .cpu_ready_i    (cpu_ready_i),
        .cpu_valid_o    (cpu_valid_o),
        .cpu_pc_o       (cpu_pc_o),
        .pred_pc_o      (pred_pc_o),
        .pred_res_o     (pred_res_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Push the expectation for the inputs just driven, then pop it against the DUT.
    task automatic tick(input string tag, input logic v, input logic [31:0] pc,
                        input logic [31:0] ppc, input logic pres);
        exp_t  e;
        string t;
        e.v = v; e.pc = pc; e.ppc = ppc; e.pres = pres;
        sb_q.push_back(e);
        tag_q.push_back(tag);
        #1;
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        check({t, ".valid"}, {31'd0, cpu_valid_o}, {31'd0, e.v});
        check({t, ".pc"}, cpu_pc_o, e.pc);
        check({t, ".pred_pc"}, pred_pc_o, e.ppc);
        check({t, ".pred_res"}, {31'd0, pred_res_o}, {31'd0, e.pres});
        @(negedge clock);
    endtask

    task automatic upd(input logic v, input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
        upd_valid = v; upd_pc = pc; upd_target = tgt; upd_taken = tk;
    endtask

    task automatic redir(input logic v, input logic [31:0] pc);
        redirect_valid = v; redirect_pc = pc;
    endtask

    initial begin
        reset = 1'b1; cpu_ready_i = 1'b1;
        redir(1'b0, 32'h0);
        upd(1'b0, 32'h0, 32'h0, 1'b0);

        tick("rst0", 1'b0, 32'h3000_0000, 32'h3000_0004, 1'b0);
        tick("rst1", 1'b0, 32'h3000_0000, 32'h3000_0004, 1'b0);
        reset = 1'b0;
        tick("rel", 1'b0, 32'h3000_0000, 32'h3000_0004, 1'b0);
        tick("f0", 1'b1, 32'h3000_0000, 32'h3000_0004, 1'b0);
        tick("f1", 1'b1, 32'h3000_0004, 32'h3000_0008, 1'b0);
        tick("f2", 1'b1, 32'h3000_0008, 32'h3000_000C, 1'b0);
        tick("f3", 1'b1, 32'h3000_000C, 32'h3000_0010, 1'b0);

        cpu_ready_i = 1'b0;
        for (int i = 0; i < 3; i++)
            tick($sformatf("stall%0d", i), 1'b1, 32'h3000_0010, 32'h3000_0014, 1'b0);
        cpu_ready_i = 1'b1;
        tick("unstall", 1'b1, 32'h3000_0010, 32'h3000_0014, 1'b0);

        redir(1'b1, 32'hA000_0000);
        tick("redir_hs", 1'b0, 32'h3000_0014, 32'h3000_0018, 1'b0);
        redir(1'b0, 32'h0);
        tick("redir_pc", 1'b1, 32'hA000_0000, 32'hA000_0004, 1'b0);
        tick("redir_nx", 1'b1, 32'hA000_0004, 32'hA000_0008, 1'b0);

        redir(1'b1, 32'hFFFF_FFFC);
        tick("wrap_rd", 1'b0, 32'hA000_0008, 32'hA000_000C, 1'b0);
        redir(1'b0, 32'h0);
        tick("wrap_top", 1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0);
        tick("wrap_zero", 1'b1, 32'h0000_0000, 32'h0000_0004, 1'b0);

        // Allocate 3000_0020 -> 3000_0100 while redirecting there.
        redir(1'b1, 32'h3000_0020);
        upd(1'b1, 32'h3000_0020, 32'h3000_0100, 1'b1);
        tick("alloc", 1'b0, 32'h0000_0004, 32'h0000_0008, 1'b0);
        redir(1'b0, 32'h0);
        upd(1'b0, 32'h0, 32'h0, 1'b0);
        cpu_ready_i = 1'b0;
        tick("hit", 1'b1, 32'h3000_0020, BP ? 32'h3000_0100 : 32'h3000_0024, BP);
        upd(1'b1, 32'h3000_0020, 32'h0, 1'b0);
        tick("nt1_old", 1'b1, 32'h3000_0020, BP ? 32'h3000_0100 : 32'h3000_0024, BP);
        tick("nt2", 1'b1, 32'h3000_0020, 32'h3000_0024, 1'b0);
        upd(1'b1, 32'h3000_0020, 32'h3000_0200, 1'b1);
        tick("tk1", 1'b1, 32'h3000_0020, 32'h3000_0024, 1'b0);
        tick("tk2_old", 1'b1, 32'h3000_0020, 32'h3000_0024, 1'b0);
        upd(1'b0, 32'h0, 32'h0, 1'b0);
        tick("tk2_new", 1'b1, 32'h3000_0020, BP ? 32'h3000_0200 : 32'h3000_0024, BP);

        cpu_ready_i = 1'b1;
        redir(1'b1, 32'h3000_0040);
        tick("alias_rd", 1'b0, 32'h3000_0020, BP ? 32'h3000_0200 : 32'h3000_0024, BP);
        redir(1'b0, 32'h0);
        cpu_ready_i = 1'b0;
        tick("alias_miss", 1'b1, 32'h3000_0040, 32'h3000_0044, 1'b0);
        upd(1'b1, 32'h3000_0040, 32'h3000_0400, 1'b0);
        tick("alias_nt", 1'b1, 32'h3000_0040, 32'h3000_0044, 1'b0);
        upd(1'b0, 32'h0, 32'h0, 1'b0);
        redir(1'b1, 32'h3000_0020);
        tick("back_rd", 1'b0, 32'h3000_0040, 32'h3000_0044, 1'b0);
        redir(1'b0, 32'h0);
        tick("kept", 1'b1, 32'h3000_0020, BP ? 32'h3000_0200 : 32'h3000_0024, BP);

        // Mid-stream reset must win over a concurrent redirect and update.
        reset = 1'b1;
        redir(1'b1, 32'hA000_0000);
        upd(1'b1, 32'h3000_0020, 32'h3000_0300, 1'b1);
        tick("mid_rst", 1'b0, 32'h3000_0000, 32'h3000_0004, 1'b0);
        reset = 1'b0;
        redir(1'b0, 32'h0);
        upd(1'b0, 32'h0, 32'h0, 1'b0);
        cpu_ready_i = 1'b1;
        tick("mid_rel", 1'b0, 32'h3000_0000, 32'h3000_0004, 1'b0);
        tick("mid_f0", 1'b1, 32'h3000_0000, 32'h3000_0004, 1'b0);
        redir(1'b1, 32'h3000_0020);
        tick("inv_rd", 1'b0, 32'h3000_0004, 32'h3000_0008, 1'b0);
        redir(1'b0, 32'h0);
        cpu_ready_i = 1'b0;
        tick("inv_miss", 1'b1, 32'h3000_0020, 32'h3000_0024, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
